// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit core: opcode values, instruction field
// positions and the fetch FSM state encoding.
package cpu8_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 2;
    localparam int IMM_MSB = 1;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction memory req/ack, issue to decode
// (valid/ready) and PC redirect from execute. "master" is the fetch unit side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [1:0]         opcode;
    logic [ADDR_W-1:0]  instr_pc;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, opcode, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, opcode, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: reset value, redirect load (wins over increment) and
// increment that wraps modulo 2^ADDR_W. Exposes the next value so the
// fetch FSM can capture the request address on the same edge.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_d_o
);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // next PC: redirect beats increment
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign pc_d_o = pc_d;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: one instruction in flight, fetched over req/ack and
// issued to decode over valid/ready, with PC redirects from execute.
//
// state    | meaning
// FS_IDLE  | no request; waits for enable
// FS_FETCH | imem_req high at imem_addr; waits for ack (kill drops stale data)
// FS_ISSUE | instr_valid high; holds instr until accepted or redirected
module instr_fetch_unit
    import cpu8_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    instr_fetch_unit_if.master  bus,
    output logic [CNT_W-1:0]    issued_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_q;
    logic               kill_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               pc_inc;

    // a non-killed ack advances the PC; a same-cycle redirect overrides it
    assign pc_inc = (state_q == FS_FETCH) && bus.imem_ack && !kill_q;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bus.redirect_valid),
        .load_val_i (bus.redirect_pc),
        .inc_i      (pc_inc),
        .pc_o       (pc_q),
        .pc_d_o     (pc_d)
    );

    // fetch FSM; imem_addr is its own register so a redirect during an
    // outstanding request cannot disturb the address the memory is serving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            kill_q     <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (enable) begin
                        state_q <= FS_FETCH;
                        addr_q  <= pc_d;
                    end
                end
                FS_FETCH: begin
                    if (bus.imem_ack) begin
                        kill_q <= 1'b0;
                        if (!kill_q && !bus.redirect_valid) begin
                            state_q    <= FS_ISSUE;
                            instr_q    <= bus.imem_rdata;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                        end else begin
                            // stale data dropped; re-request at the live PC
                            addr_q <= pc_d;
                        end
                    end else if (bus.redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                FS_ISSUE: begin
                    if (bus.instr_ready || bus.redirect_valid) begin
                        valid_q <= 1'b0;
                        if (bus.instr_ready) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (enable) begin
                            state_q <= FS_FETCH;
                            addr_q  <= pc_d;
                        end else begin
                            state_q <= FS_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= FS_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req    = (state_q == FS_FETCH);
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: 2];
    assign bus.instr_pc    = instr_pc_q;
    assign issued_cnt      = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle vector table, directed multi-cycle
// sequences, random traffic against a transaction-level model, and a second
// instance with RESET_PC=0xFE for PC wrap.
module tb_instr_fetch_unit;
    import cpu8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) bus_a ();
    instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) bus_b ();

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .bus(bus_a), .issued_cnt(cnt_a));

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'hFE), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .bus(bus_b), .issued_cnt(cnt_b));

    typedef struct {
        logic        en;
        logic        ack;
        logic [7:0]  rdata;
        logic        rdy;
        logic        redir;
        logic [7:0]  rpc;
        logic        x_req;
        logic [7:0]  x_addr;
        logic        x_valid;
        logic [7:0]  x_instr;
        logic [7:0]  x_ipc;
        logic [15:0] x_cnt;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] mem [256];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic en, input logic ack, input logic [7:0] rdata,
                       input logic rdy, input logic redir, input logic [7:0] rpc,
                       input logic xreq, input logic [7:0] xaddr, input logic xval,
                       input logic [7:0] xinstr, input logic [7:0] xipc, input logic [15:0] xcnt);
        vec_t v;
        v.en = en; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.x_req = xreq; v.x_addr = xaddr; v.x_valid = xval;
        v.x_instr = xinstr; v.x_ipc = xipc; v.x_cnt = xcnt;
        tbl.push_back(v);
    endtask

    task automatic drv(input logic en, input logic ack, input logic [7:0] rdata,
                       input logic rdy, input logic redir, input logic [7:0] rpc);
        en_a                 = en;
        bus_a.imem_ack       = ack;
        bus_a.imem_rdata     = rdata;
        bus_a.instr_ready    = rdy;
        bus_a.redirect_valid = redir;
        bus_a.redirect_pc    = rpc;
    endtask

    initial begin
        logic       pend;
        int         wl;
        int         acc;
        int         got_n;
        logic       p_req, p_ack, p_val, p_rdy, p_red;
        logic [7:0] p_addr, p_instr, p_ipc;
        logic [7:0] m_pc;
        logic [15:0] m_cnt;
        logic [7:0] e;
        logic [7:0] seq [3];

        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        bus_b.imem_ack = 1'b0; bus_b.imem_rdata = 8'h00; bus_b.instr_ready = 1'b0;
        bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // two-fetch table: 0-latency memory, then redirect in ISSUE (drop / accept)
        //   en    ack   rdata  rdy   redir rpc    | req   addr   valid instr  ipc    cnt
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0);
        add(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00,  1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 8'h40, 8'h00, 16'd0);
        add(1'b1, 1'b1, 8'hC5, 1'b0, 1'b0, 8'h00,  1'b1, 8'h01, 1'b0, 8'h40, 8'h00, 16'd1);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00,  1'b0, 8'h01, 1'b1, 8'hC5, 8'h01, 16'd1);
        add(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00,  1'b1, 8'h02, 1'b0, 8'hC5, 8'h01, 16'd2);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00,  1'b0, 8'h02, 1'b1, 8'h80, 8'h02, 16'd2);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,  1'b0, 8'h02, 1'b0, 8'h80, 8'h02, 16'd3);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,  1'b0, 8'h02, 1'b0, 8'h80, 8'h02, 16'd3);
        add(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00,  1'b1, 8'h03, 1'b0, 8'h80, 8'h02, 16'd3);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10,  1'b0, 8'h03, 1'b1, 8'h11, 8'h03, 16'd3);
        add(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00,  1'b1, 8'h10, 1'b0, 8'h11, 8'h03, 16'd3);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10,  1'b0, 8'h10, 1'b1, 8'h22, 8'h10, 16'd3);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,  1'b1, 8'h10, 1'b0, 8'h22, 8'h10, 16'd4);
        add(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00,  1'b1, 8'h10, 1'b0, 8'h22, 8'h10, 16'd4);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00,  1'b0, 8'h10, 1'b1, 8'h33, 8'h10, 16'd4);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,  1'b0, 8'h10, 1'b0, 8'h33, 8'h10, 16'd5);

        repeat (3) @(negedge clk);
        chk("reset_a", {bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid, bus_a.instr,
                        bus_a.opcode, bus_a.instr_pc, cnt_a},
                       {1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 8'h00, 16'd0});
        chk("reset_b", {bus_b.imem_req, bus_b.imem_addr, cnt_b}, {1'b0, 8'hFE, 16'd0});
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid, bus_a.instr,
                 bus_a.opcode, bus_a.instr_pc, cnt_a},
                {tbl[i].x_req, tbl[i].x_addr, tbl[i].x_valid, tbl[i].x_instr,
                 tbl[i].x_instr[7:6], tbl[i].x_ipc, tbl[i].x_cnt});
            drv(tbl[i].en, tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
        end

        // kill path: redirect to 0x20 while the fetch of 0x05 is outstanding
        @(negedge clk); drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05);
        @(negedge clk); chk("kill_req5", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h05});
        drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20);
        @(negedge clk); chk("kill_hold", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h05});
        drv(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("kill_refetch", {bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid},
                            {1'b1, 8'h20, 1'b0});
        drv(1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("kill_issue", {bus_a.instr_valid, bus_a.instr, bus_a.instr_pc, cnt_a},
                            {1'b1, 8'h5C, 8'h20, 16'd5});
        drv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        @(negedge clk); chk("kill_cnt", {bus_a.imem_req, bus_a.instr_valid, cnt_a}, {1'b0, 1'b0, 16'd6});
        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // enable dropped mid-fetch: request completes, instruction issues, then idle
        @(negedge clk); drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("enlo_req", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h21});
        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("enlo_hold", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h21});
        drv(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("enlo_issue", {bus_a.instr_valid, bus_a.instr, bus_a.opcode, bus_a.instr_pc},
                            {1'b1, 8'h99, OP_STORE, 8'h21});
        drv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        @(negedge clk); chk("enlo_idle", {bus_a.imem_req, bus_a.instr_valid, cnt_a}, {1'b0, 1'b0, 16'd7});
        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("enlo_stay", {bus_a.imem_req, bus_a.instr_valid}, {1'b0, 1'b0});

        // reset asserted with a request outstanding
        drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("rst_pre", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h22});
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {bus_a.imem_req, bus_a.imem_addr, bus_a.instr_valid, cnt_a},
                            {1'b0, 8'h00, 1'b0, 16'd0});
        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        drv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        @(negedge clk); chk("rst_refetch", {bus_a.imem_req, bus_a.imem_addr}, {1'b1, 8'h00});

        // random traffic: model predicts the accepted pc sequence and count
        pend = 1'b0; wl = 0; acc = 0;
        p_req = 1'b0; p_ack = 1'b0; p_val = 1'b0; p_rdy = 1'b0; p_red = 1'b0;
        p_addr = 8'h00; p_instr = 8'h00; p_ipc = 8'h00;
        m_pc = 8'h00; m_cnt = 16'd0;
        for (int c = 0; c < 4000; c++) begin
            logic       en, ak, rdy, red;
            logic [7:0] rpc;
            if (c > 0) @(negedge clk);
            chk("rnd_cnt", cnt_a, m_cnt);
            if (c > 0 && p_req && !p_ack && bus_a.imem_req)
                chk("rnd_addr_stable", bus_a.imem_addr, p_addr);
            if (c > 0 && p_val && !p_rdy && !p_red)
                chk("rnd_hold", {bus_a.instr_valid, bus_a.instr, bus_a.instr_pc}, {1'b1, p_instr, p_ipc});
            en  = ($urandom_range(0, 15) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            red = ($urandom_range(0, 24) == 0);
            rpc = 8'($urandom);
            if (bus_a.imem_req && !pend) begin
                pend = 1'b1;
                wl   = $urandom_range(0, 3);
            end
            ak = bus_a.imem_req && pend && (wl == 0);
            if (ak) pend = 1'b0;
            else if (pend) wl--;
            if (bus_a.instr_valid && rdy) begin
                e = mem[m_pc];
                chk("rnd_pc", bus_a.instr_pc, m_pc);
                chk("rnd_instr", {bus_a.instr, bus_a.opcode}, {e, e[7:6]});
                m_pc  = m_pc + 8'd1;
                m_cnt = m_cnt + 16'd1;
                acc++;
            end
            if (red) m_pc = rpc;
            drv(en, ak, mem[bus_a.imem_addr], rdy, red, rpc);
            p_req = bus_a.imem_req; p_ack = ak; p_addr = bus_a.imem_addr;
            p_val = bus_a.instr_valid; p_rdy = rdy; p_red = red;
            p_instr = bus_a.instr; p_ipc = bus_a.instr_pc;
        end
        chk("rnd_progress", 64'(acc > 200), 64'd1);
        drv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // RESET_PC=0xFE instance: pc wraps FE, FF, 00
        got_n = 0;
        for (int i = 0; i < 3; i++) seq[i] = 8'hAA;
        for (int c = 0; c < 40 && got_n < 3; c++) begin
            @(negedge clk);
            if (bus_b.instr_valid) begin
                seq[got_n] = bus_b.instr_pc;
                got_n++;
            end
            en_b = 1'b1;
            bus_b.instr_ready = 1'b1;
            bus_b.imem_ack    = bus_b.imem_req;
            bus_b.imem_rdata  = 8'h3C;
        end
        chk("wrap_count", 64'(got_n), 64'd3);
        chk("wrap_pc0", seq[0], 8'hFE);
        chk("wrap_pc1", seq[1], 8'hFF);
        chk("wrap_pc2", seq[2], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 8-bit core; produces the opcode stream the control unit decodes.
- Owns the PC and fetches 8-bit instructions from instruction memory over a req/ack handshake with variable latency.
- Issues each instruction with its PC to the decode stage over a valid/ready handshake, and accepts PC redirects from execute.
- Sequential block: PC register, 3-state FSM, kill flag and issue counter.

Parameters:
ADDR_W  8  instruction address width; the PC wraps modulo 2^ADDR_W
INSTR_W  8  instruction width; opcode is bits [INSTR_W-1:INSTR_W-2]
RESET_PC  0  PC value loaded on reset
CNT_W  16  width of the issued-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  fetch enable; low means drain, then idle
imem_req  out  1  fetch request, held until acknowledged
imem_addr  out  ADDR_W  fetch address, stable while imem_req is high
imem_ack  in  1  memory response valid; imem_rdata sampled in the same cycle
imem_rdata  in  INSTR_W  fetched instruction
instr_valid  out  1  issued instruction valid
instr_ready  in  1  decode stage accepts
instr  out  INSTR_W  issued instruction
opcode  out  2  instr[INSTR_W-1:INSTR_W-2], feeds the control unit
instr_pc  out  ADDR_W  PC of the issued instruction
redirect_valid  in  1  load new PC (branch or jump)
redirect_pc  in  ADDR_W  target PC
issued_cnt  out  CNT_W  count of accepted instructions; wraps

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, pc=RESET_PC, kill=0, issued_cnt=0.
- Reset values of outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, opcode=0, instr_pc=0.
- Reset asserted mid-operation: any outstanding request is abandoned and imem_req drops immediately. Memory must ignore a req that vanishes.
- IDLE: imem_req=0. If enable=1, go to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack=1 with kill=0: latch imem_rdata into instr, latch pc into instr_pc, pc<=pc+1 (mod 2^ADDR_W, 0xFF+1=0x00), go to ISSUE.
  - Earliest ack is the first cycle req is high, so latency from entering FETCH to instr_valid is 1 cycle plus memory latency.
  - On ack with kill=1: discard the data, clear kill, stay in FETCH. A new request to the current pc is issued in the following cycle.
- ISSUE: instr_valid=1. instr, opcode and instr_pc are held stable until accepted.
  - On instr_ready=1: issued_cnt++ (wraps). Go to FETCH if enable=1, else IDLE.
  - Fetch does not overlap issue: at most one instruction is in flight.
- Redirect (highest priority over pc update):
  - In IDLE: pc<=redirect_pc.
  - In FETCH without ack: pc<=redirect_pc and kill<=1, but only if req is already high. Redirect arriving in the same cycle FETCH is entered with req not yet seen is not a special case, because req is combinational from state. So kill is set for any FETCH-state redirect without ack.
  - In FETCH with ack in the same cycle: data is discarded, pc<=redirect_pc, stay in FETCH, kill stays 0.
  - In ISSUE without ready: the instruction is dropped, instr_valid=0 next cycle, pc<=redirect_pc, go to FETCH (or IDLE if enable=0). It is not counted.
  - In ISSUE with ready: the instruction counts as accepted, pc<=redirect_pc.
- imem_addr changes only on entry to FETCH or after a killed ack, never while req is high and unacknowledged.
- enable=0 in FETCH: the outstanding request completes. The instruction is issued normally, then the FSM goes to IDLE.

Decomposition:
- Shared package cpu8_pkg:
  - opcode constants OP_NOP=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_ALU=2'b11
  - instruction field positions: opcode [7:6], rd [5:4], rs [3:2], imm [1:0]
  - fetch FSM state encoding FS_IDLE, FS_FETCH, FS_ISSUE
- One sub-module: fetch_pc_reg. It is the PC register with reset value, increment, redirect load and wrap.

Test Plan:
- Reset release, enable=1, memory with 0-cycle ack returning 0x40,0xC5,0x80 at addresses 0..2 -> issued (pc,instr,opcode) = (0,0x40,01), (1,0xC5,11), (2,0x80,10); issued_cnt=3.
- Memory latency of 3 cycles and decode stall of instr_ready=0 for 4 cycles -> imem_addr stable while req high; instr/opcode/instr_pc stable while valid and not ready; no duplicate or lost instruction.
- Redirect to 0x20 asserted while a fetch of 0x05 is pending (kill path) -> the ack for 0x05 is discarded; the next issued instr_pc=0x20; issued_cnt excludes 0x05.
- Redirect to 0x10 in ISSUE with instr_ready=0, then redirect in ISSUE with instr_ready=1 -> first instruction dropped (not counted); second counted; next fetch address is 0x10 in both cases.
- RESET_PC=0xFE, run 3 instructions -> instr_pc sequence 0xFE, 0xFF, 0x00.
- rst_n asserted mid-FETCH with req high, and separately enable=0 mid-FETCH -> reset: imem_req=0 immediately, pc=RESET_PC, issued_cnt=0. Enable-low: pending instruction is issued, then the FSM idles with imem_req=0.
